// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared types for keypad scanner, key capture and display decode
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    typedef logic [3:0] key_code_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_key_capture_sync2.sv
`default_nettype none
// ============================================================================
// sync2    : parameterised-width two-flop synchronizer, async active-low reset
// Revision : 1.0
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/keypad_key_capture.sv
`default_nettype none
// ============================================================================
// keypad_key_capture : debounces scanner key events and keeps a two-digit
//                      history for the seven-segment display mux
// Revision           : 1.0
// ============================================================================
module keypad_key_capture
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_hex,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic [1:0] digits_valid,
    output logic       key_pressed
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            w_valid_s;
    key_code_t       w_hex_s;

    debounce_state_t r_state;
    debounce_state_t w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    key_code_t       r_cand;
    key_code_t       w_cand_nxt;
    logic            w_accept;

    key_code_t       r_digit_new;
    key_code_t       r_digit_old;
    logic [1:0]      r_digits_valid;
    logic            r_key_pressed;

    // key_valid and key_hex come from the keypad columns, so both are resynchronised.
    sync2 #(.WIDTH(1)) u_sync_valid (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (key_valid),
        .q       (w_valid_s)
    );

    sync2 #(.WIDTH(4)) u_sync_hex (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (key_hex),
        .q       (w_hex_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid_s) begin
                    w_cand_nxt  = w_hex_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!w_valid_s) begin
                    w_state_nxt = IDLE;
                end else if (w_hex_s != r_cand) begin
                    // A different code while still settling restarts the window.
                    w_cand_nxt = w_hex_s;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = HELD;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_valid_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (w_valid_s) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit_new    <= '0;
            r_digit_old    <= '0;
            r_digits_valid <= 2'b00;
            r_key_pressed  <= 1'b0;
        end else begin
            r_key_pressed <= w_accept;
            if (w_accept) begin
                r_digit_old    <= r_digit_new;
                r_digit_new    <= r_cand;
                r_digits_valid <= {r_digits_valid[0], 1'b1};
            end
        end
    end

    assign digit_new    = r_digit_new;
    assign digit_old    = r_digit_old;
    assign digits_valid = r_digits_valid;
    assign key_pressed  = r_key_pressed;

endmodule : keypad_key_capture
`default_nettype wire

// File: tb/tb_keypad_key_capture.sv
`default_nettype none
// ============================================================================
// tb_keypad_key_capture : self-checking bench for keypad_key_capture
// Revision              : 1.0
// ============================================================================
module tb_keypad_key_capture;

    localparam int c_DEB = 4;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [3:0] key_hex;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic [1:0] digits_valid;
    logic       key_pressed;

    keypad_key_capture #(.DEBOUNCE_CYCLES(c_DEB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_valid    (key_valid),
        .key_hex      (key_hex),
        .digit_new    (digit_new),
        .digit_old    (digit_old),
        .digits_valid (digits_valid),
        .key_pressed  (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] exp_new;
        logic [3:0] exp_old;
        logic [1:0] exp_dv;
    } event_t;

    typedef struct {
        logic [3:0] hex;
        int         hold;
        int         rel;
        logic [3:0] exp_new;
        logic [3:0] exp_old;
        logic [1:0] exp_dv;
    } vec_t;

    event_t exp_q[$];
    vec_t   vecs[6];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] n, input logic [3:0] o, input logic [1:0] dv);
        event_t e;
        e.exp_new = n;
        e.exp_old = o;
        e.exp_dv  = dv;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digit_new"}, 32'(digit_new), 32'h0);
        chk({tag, "_digit_old"}, 32'(digit_old), 32'h0);
        chk({tag, "_digits_valid"}, 32'(digits_valid), 32'h0);
        chk({tag, "_key_pressed"}, 32'(key_pressed), 32'h0);
    endtask

    // Pulse must appear exactly at edge pulse_edge (counted from the reference point).
    task automatic chk_pulse_at(input string tag, input int pulse_edge, input int n_edges);
        for (int e = 1; e <= n_edges; e++) begin
            tick();
            chk($sformatf("%s_pulse_e%0d", tag, e), 32'(key_pressed), 32'(e == pulse_edge));
        end
    endtask

    // Scoreboard: every observed pulse consumes one expected event.
    always @(negedge clk) begin
        if (reset_n && key_pressed) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'h1, 32'h0);
            end else begin
                event_t e;
                e = exp_q.pop_front();
                chk("sb_digit_new", 32'(digit_new), 32'(e.exp_new));
                chk("sb_digit_old", 32'(digit_old), 32'(e.exp_old));
                chk("sb_digits_valid", 32'(digits_valid), 32'(e.exp_dv));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'h3, 10, 10, 4'h3, 4'h0, 2'b01};
        vecs[1] = '{4'hA, 10, 10, 4'hA, 4'h3, 2'b11};
        vecs[2] = '{4'h5, 10, 10, 4'h5, 4'hA, 2'b11};
        vecs[3] = '{4'h5, 10, 10, 4'h5, 4'h5, 2'b11};
        vecs[4] = '{4'h0, 12, 10, 4'h0, 4'h5, 2'b11};
        vecs[5] = '{4'hC, 10, 10, 4'hC, 4'h0, 2'b11};

        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_hex   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        #3 reset_n = 1'b1;

        // Clean press: 7 held from edge 0, pulse at edge 7.
        tick();
        key_valid = 1'b1;
        key_hex   = 4'h7;
        push(4'h7, 4'h0, 2'b01);
        chk_pulse_at("clean", 7, 10);
        key_valid = 1'b0;
        repeat (10) tick();
        chk("clean_drained", 32'(exp_q.size()), 32'h0);

        // Fresh history for the press table.
        #3 reset_n = 1'b0;
        #1 chk_zero("reset2");
        #2 reset_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_hex   = vecs[i].hex;
            push(vecs[i].exp_new, vecs[i].exp_old, vecs[i].exp_dv);
            repeat (vecs[i].hold) tick();
            key_valid = 1'b0;
            key_hex   = 4'h0;
            repeat (vecs[i].rel) tick();
            chk($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'h0);
            chk($sformatf("vec%0d_digit_new", i), 32'(digit_new), 32'(vecs[i].exp_new));
        end

        // Press bounce: 1,0,1,0 then stable high from edge 4; pulse 7 edges later.
        key_hex = 4'h9;
        push(4'h9, 4'hC, 2'b11);
        key_valid = 1'b1; tick();
        key_valid = 1'b0; tick();
        key_valid = 1'b1; tick();
        key_valid = 1'b0; tick();
        key_valid = 1'b1;
        chk_pulse_at("bounce", 7, 10);

        // Release bounce and rollover while 9 is held.
        key_valid = 1'b0;
        repeat (2) tick();
        key_valid = 1'b1;
        key_hex   = 4'hF;
        repeat (20) tick();
        chk("rollover_digit_new", 32'(digit_new), 32'h9);
        chk("rollover_digit_old", 32'(digit_old), 32'hC);
        key_valid = 1'b0;
        repeat (12) tick();
        chk("rollover_drained", 32'(exp_q.size()), 32'h0);

        // Reset mid-PRESS_WAIT, then a full debounce from release.
        key_valid = 1'b1;
        key_hex   = 4'h2;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_pw");
        #1 reset_n = 1'b1;
        push(4'h2, 4'h0, 2'b01);
        chk_pulse_at("rst_pw", 7, 10);

        // Reset mid-HELD with the key still down.
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_held");
        #1 reset_n = 1'b1;
        push(4'h2, 4'h0, 2'b01);
        chk_pulse_at("rst_held", 7, 10);
        key_valid = 1'b0;
        repeat (12) tick();
        chk("final_drained", 32'(exp_q.size()), 32'h0);
        chk("final_digits_valid", 32'(digits_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_keypad_key_capture
`default_nettype wire
